// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end with a DEPTH-entry prefetch queue. Issues at
// most one request at a time to a variable-latency instruction memory,
// queues the returned words with their PCs, and presents the queue head to
// decode with a valid/ready handshake. A redirect flushes the queue and any
// in-flight fetch, and restarts fetching at the new PC.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem_req        one-cycle request pulse
//   imem_addr       request address (word aligned)
//   imem_rvalid     in-order response strobe
//   imem_rdata      response instruction word
//   id_valid        queue head valid
//   id_ready        decode accepts head this cycle
//   id_instr        head instruction (NOP when empty)
//   id_pc           head PC (0 when empty)
//   redirect        flush and restart fetch
//   redirect_pc     restart PC (low two bits ignored)
//   q_count         queue occupancy
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = 'h13
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_rvalid,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_instr,
    output logic [XLEN-1:0]            id_pc,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,   // no request outstanding
        S_WAIT    = 2'd1,   // one live request outstanding
        S_DISCARD = 2'd2    // one stale request outstanding; drop its data
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   count_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW-1:0]   count_next;
    logic [XLEN-1:0] fetch_pc_inc;

    logic [XLEN-1:0] entry_pc    [DEPTH];
    logic [XLEN-1:0] entry_instr [DEPTH];

    // Head outputs come only from queue registers, never from imem_rdata.
    assign id_valid = (count_reg != '0);
    assign id_pc    = id_valid ? entry_pc[rd_ptr_reg]    : '0;
    assign id_instr = id_valid ? entry_instr[rd_ptr_reg] : NOP;
    assign q_count  = count_reg;

    // A redirect suppresses both queue operations in its cycle.
    assign pop  = id_valid & id_ready & ~redirect;
    assign push = imem_rvalid & (state_reg == S_WAIT) & ~redirect;

    assign count_next   = count_reg + CW'(push) - CW'(pop);
    // fetch_pc always names the address of the next word to be queued, so
    // after a push it already points at the next request address.
    assign fetch_pc_inc = push ? (fetch_pc_reg + XLEN'(4)) : fetch_pc_reg;

    // Back-to-back issue is allowed in WAIT on the response cycle; the
    // occupancy test uses count_next so a same-cycle pop frees a slot.
    assign issue = ~rst & ~redirect & (count_next < CW'(DEPTH)) &
                   ((state_reg == S_FETCH) | ((state_reg == S_WAIT) & imem_rvalid));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: begin
                if (issue) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    // issue is already forced low by a same-cycle redirect
                    state_next = issue ? S_WAIT : S_FETCH;
                end else if (redirect) begin
                    state_next = S_DISCARD;
                end
            end
            S_DISCARD: begin
                // The stale response retires the outstanding request even
                // if another redirect arrives in the same cycle.
                if (imem_rvalid) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req  = issue;
        imem_addr = fetch_pc_inc;
    end

    // Fetch PC, occupancy and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg <= RESET_PC & ALIGN_MASK;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else if (redirect) begin
            fetch_pc_reg <= redirect_pc & ALIGN_MASK;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_inc;
            count_reg    <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // Queue storage: one {pc, instr} register pair per entry. Contents need
    // no reset because the head outputs are masked while the queue is empty.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [XLEN-1:0] pc_reg;
            logic [XLEN-1:0] instr_reg;

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    pc_reg    <= fetch_pc_reg;
                    instr_reg <= imem_rdata;
                end
            end

            assign entry_pc[gi]    = pc_reg;
            assign entry_instr[gi] = instr_reg;
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Scoreboard bench for fetch_queue. The stimulus process drives reset,
// redirect, id_ready and a memory responder with configurable latency whose
// data is a fixed function of the address. A monitor process keeps the
// expected decode stream (consecutive PCs from the last redirect/reset
// target) in a queue and compares every pop and every request against it.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .q_count     (q_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int pop_count = 0;
    int last_rv_cyc = -1;
    int lat_min = 1;
    int lat_max = 1;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus: inputs change on the falling edge, the
    // memory answers the oldest due request, and a request seen just before
    // the rising edge is recorded with its response cycle.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        id_ready    = rdy;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            last_rv_cyc = cyc;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #4;
        if (imem_req === 1'b1) begin
            pend.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
    endtask

    task automatic do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [31:0] next_pc;
        logic [31:0] req_exp;
        logic [63:0] exp_q[$];
        logic [63:0] e;
        next_pc = RESET_PC;
        req_exp = RESET_PC;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                check("req_in_reset", {31'b0, imem_req}, 32'd0);
                exp_q.delete();
                next_pc = RESET_PC;
                req_exp = RESET_PC;
            end else begin
                while (exp_q.size() < 2) begin
                    exp_q.push_back({next_pc, mem_word(next_pc)});
                    next_pc = next_pc + 32'd4;
                end
                check("valid_vs_count", {31'b0, id_valid}, {31'b0, (q_count != 3'd0)});
                check("count_bound", {31'b0, (q_count <= 3'(DEPTH))}, 32'd1);
                if (!id_valid) begin
                    check("empty_instr", id_instr, NOP);
                    check("empty_pc", id_pc, 32'd0);
                end
                if (imem_req) begin
                    check("one_outstanding", pend.size(), 32'd0);
                    check("req_addr", imem_addr, req_exp);
                    req_exp = req_exp + 32'd4;
                end
                if (id_valid && id_ready && !redirect) begin
                    e = exp_q.pop_front();
                    $display("[TB] pop pc=%h instr=%h", id_pc, id_instr);
                    check("pop_pc", id_pc, e[63:32]);
                    check("pop_instr", id_instr, e[31:0]);
                    pop_count++;
                end
                if (redirect) begin
                    check("req_on_redirect", {31'b0, imem_req}, 32'd0);
                    exp_q.delete();
                    next_pc = redirect_pc & 32'hFFFF_FFFC;
                    req_exp = redirect_pc & 32'hFFFF_FFFC;
                end
            end
        end
    end

    // Stimulus
    initial begin
        int nreq;
        int found;
        int pops_before;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset values
        do_reset();
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        check("rst_instr", id_instr, NOP);
        check("rst_pc", id_pc, 32'd0);
        check("rst_count", {29'b0, q_count}, 32'd0);
        check("rst_req", {31'b0, imem_req}, 32'd0);

        // Streaming with 1-cycle memory
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("first_req", {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check("stream_valid", {31'b0, id_valid}, 32'd1);
            check("stream_pc", id_pc, RESET_PC + 32'(4 * i));
            check("stream_req", {31'b0, imem_req}, 32'd1);
        end

        // Fill with decode stalled, then drain while refilling
        do_reset();
        nreq = 0;
        repeat (10) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (imem_req) nreq++;
        end
        check("fill_reqs", nreq, DEPTH);
        check("fill_count", {29'b0, q_count}, DEPTH);
        check("fill_req_idle", {31'b0, imem_req}, 32'd0);
        check("fill_head", id_pc, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("pop_full_req", {31'b0, imem_req}, 32'd1);
        check("pop_full_count", {29'b0, q_count}, DEPTH);
        repeat (4) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check("steady_count", {29'b0, q_count}, DEPTH - 1);
        end

        // Redirect while a 3-cycle request is in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req && imem_addr == 32'h108) found = 1;
        end
        check("saw_req_108", found, 32'd1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        check("redir_no_req", {31'b0, imem_req}, 32'd0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (imem_req) found = 1;
        end
        check("redir_req_seen", found, 32'd1);
        check("redir_addr", imem_addr, 32'h200);
        check("redir_after_stale", cyc, last_rv_cyc + 1);
        check("stale_dropped", {29'b0, q_count}, 32'd0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (id_valid) found = 1;
        end
        check("redir_first_valid", found, 32'd1);
        check("redir_first_pc", id_pc, 32'h200);

        // Redirect coincident with a response and a pop at count 2
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h303, 1'b1);
        check("pre_redir_count", {29'b0, q_count}, 32'd2);
        check("redir_rvalid_req", {31'b0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("flush_count", {29'b0, q_count}, 32'd0);
        check("flush_valid", {31'b0, id_valid}, 32'd0);
        check("new_req", {31'b0, imem_req}, 32'd1);
        check("new_addr", imem_addr, 32'h300);

        // Fetch across the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (id_valid && id_pc == 32'h0) found = 1;
        end
        check("pc_wrap_seen", found, 32'd1);

        // Random traffic: random latency, stalls and redirects
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, ($urandom_range(99, 0) < 4), $urandom, ($urandom_range(9, 0) < 6));
        end
        pops_before = pop_count;
        repeat (40) step(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_progress", {31'b0, (pop_count > pops_before)}, 32'd1);

        // Reset while WAIT, stray response right after release
        lat_min = 1; lat_max = 1;
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wait_req", {31'b0, imem_req}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst2_valid", {31'b0, id_valid}, 32'd0);
        check("rst2_instr", id_instr, NOP);
        check("rst2_pc", id_pc, 32'd0);
        check("rst2_count", {29'b0, q_count}, 32'd0);
        check("rst2_req", {31'b0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_rst_req", {31'b0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("stray_not_queued", {29'b0, q_count}, 32'd0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (id_valid) found = 1;
        end
        check("post_rst_valid", found, 32'd1);
        check("post_rst_pc", id_pc, RESET_PC);
        check("post_rst_instr", id_instr, mem_word(RESET_PC));
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
